// File: rtl/uart_rx_if.sv
// Serial-side and consumer-side signal bundle for uart_rx.
// master: line driver / consumer (bench); slave: the receiver.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STP_ERR;
  logic                  BUSY;

  modport master (
    output RX_IN,
    output PAR_EN,
    output PAR_TYP,
    input  P_DATA,
    input  DATA_VALID,
    input  PAR_ERR,
    input  STP_ERR,
    input  BUSY
  );

  modport slave (
    input  RX_IN,
    input  PAR_EN,
    input  PAR_TYP,
    output P_DATA,
    output DATA_VALID,
    output PAR_ERR,
    output STP_ERR,
    output BUSY
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_WIDTH bits LSB first, opt. parity, stop.
// Ports: CLK, RST (async low), bus (uart_rx_if.slave: RX_IN/PAR_*/outputs).
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic     CLK,
  input  logic     RST,
  uart_rx_if.slave bus
);

  localparam int EW = $clog2(PRESCALE);
  localparam int BL = $clog2(DATA_WIDTH);
  localparam int BW = (BL > 0) ? BL : 1;

  localparam logic [EW-1:0] E_SMP  = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] E_LAST = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] E_ONE  = EW'(1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] B_ONE  = BW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state;
  state_t state_n;

  logic                  rx_m;
  logic                  rx_s;
  logic [EW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_bad;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  logic sample;
  logic wrap;
  logic par_exp;
  logic done;
  logic frame_ok;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.RX_IN;
      rx_s <= rx_m;
    end
  end

  assign sample   = (edge_cnt == E_SMP);
  assign wrap     = (edge_cnt == E_LAST);
  assign par_exp  = (^shift) ^ par_typ_q;
  // Stop is evaluated at its sample point, not at the wrap,
  // so a following start edge is never missed.
  assign done     = (state == STOP) && sample;
  assign frame_ok = !par_bad && rx_s;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (!rx_s) state_n = START;
      START:
        if (sample && rx_s) state_n = IDLE;
        else if (wrap)      state_n = DATA;
      DATA:
        if (wrap && bit_cnt == B_LAST)
          state_n = par_en_q ? PARITY : STOP;
      PARITY:
        if (wrap) state_n = STOP;
      STOP:
        if (sample) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad    <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      if (state == IDLE || state_n == IDLE || wrap)
        edge_cnt <= '0;
      else
        edge_cnt <= edge_cnt + E_ONE;

      if (state != DATA) bit_cnt <= '0;
      else if (wrap)     bit_cnt <= bit_cnt + B_ONE;

      if (state == DATA && sample)
        shift <= {rx_s, shift[DATA_WIDTH-1:1]};

      if (state == IDLE) begin
        par_bad <= 1'b0;
        if (!rx_s) begin
          par_en_q  <= bus.PAR_EN;
          par_typ_q <= bus.PAR_TYP;
        end
      end else if (state == PARITY && sample) begin
        par_bad <= (rx_s != par_exp);
      end

      data_valid <= done && frame_ok;
      par_err    <= done && par_bad;
      stp_err    <= done && !rx_s;
      if (done && frame_ok) p_data <= shift;
    end
  end

  assign bus.P_DATA     = p_data;
  assign bus.DATA_VALID = data_valid;
  assign bus.PAR_ERR    = par_err;
  assign bus.STP_ERR    = stp_err;
  assign bus.BUSY       = (state != IDLE);

endmodule
